// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One bit of the packed BCD operand moves into the binary accumulator on each clock.
module bcd2bin #(
   parameter int unsigned W = 32,
   parameter int unsigned D = 10
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [4*D-1:0] bcd_in,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   bin_out,
   output logic           overflow,
   output logic           invalid
);

   localparam int unsigned N    = 4 * D;
   localparam int unsigned CntW = $clog2(N + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    sr_q, sr_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W-1:0]    bin_q, bin_d;
   logic            ovf_q, ovf_d;
   logic            inv_q, inv_d;

   logic            in_bad;
   logic            last_iter;
   logic [N-1:0]    sr_shift, sr_adj, acc_shift;
   logic [W-1:0]    res_bin;
   logic            res_ovf;

   always_comb begin
      in_bad = 1'b0;
      for (int unsigned i = 0; i < D; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // A digit >= 8 after the right shift held a 10+ weight before it; subtract 3 to re-base it.
   always_comb begin
      sr_shift  = {1'b0, sr_q[N-1:1]};
      acc_shift = {sr_q[0], acc_q[N-1:1]};
      sr_adj    = sr_shift;
      for (int unsigned i = 0; i < D; i++) begin
         if (sr_shift[4*i+3]) sr_adj[4*i +: 4] = sr_shift[4*i +: 4] - 4'd3;
      end
   end

   generate
      if (W >= N) begin : g_wide
         assign res_bin = W'(acc_shift);
         assign res_ovf = 1'b0;
      end else begin : g_narrow
         assign res_bin = acc_shift[W-1:0];
         assign res_ovf = |acc_shift[N-1:W];
      end
   endgenerate

   assign last_iter = (cnt_q == CntW'(N - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bin_q   <= '0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bin_q   <= bin_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = in_bad ? StDone : StShift;
         StShift: if (last_iter) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sr_d   = sr_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      bin_d  = bin_q;
      ovf_d  = ovf_q;
      inv_d  = inv_q;
      busy_d = (state_d == StShift);
      done_d = (state_d == StDone);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sr_d  = bcd_in;
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
               inv_d = in_bad;
               if (in_bad) bin_d = '0;
            end
         end
         StShift: begin
            sr_d  = sr_adj;
            acc_d = acc_shift;
            cnt_d = cnt_q + CntW'(1);
            if (last_iter) begin
               bin_d = res_bin;
               ovf_d = res_ovf;
            end
         end
         default: ;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bin_out  = bin_q;
   assign overflow = ovf_q;
   assign invalid  = inv_q;

endmodule
